// File: rtl/line_drive_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : line_drive_ctrl_if                                               |
// | Purpose  : Bundle of the line follower control and status signals.        |
// |            master: drives en/sensors and observes the servo/status outputs |
// |            slave : the controller itself                                   |
// | Signals  : en       drive enable                                           |
// |            sensors  line sensors (1 = line), upper half left, lower right  |
// |            servo_l  left servo command (registered)                        |
// |            servo_r  right servo command (registered)                       |
// |            state_o  current state code                                     |
// |            lost     high while stopped after a search timeout              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface line_drive_ctrl_if #(
    parameter int N_SENS = 4,
    parameter int SPD_W  = 8
);
    logic              en;
    logic [N_SENS-1:0] sensors;
    logic [SPD_W-1:0]  servo_l;
    logic [SPD_W-1:0]  servo_r;
    logic [2:0]        state_o;
    logic              lost;

    modport master (
        output en,
        output sensors,
        input  servo_l,
        input  servo_r,
        input  state_o,
        input  lost
    );

    modport slave (
        input  en,
        input  sensors,
        output servo_l,
        output servo_r,
        output state_o,
        output lost
    );
endinterface
`default_nettype wire

// File: rtl/line_drive_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : line_drive_ctrl                                                  |
// | Purpose  : Two-servo line follower controller. Decodes the left/right      |
// |            sensor halves, runs a timed turn / timed search state machine   |
// |            and produces registered servo commands.                         |
// | Ports    : clk   system clock, rising edge                                 |
// |            rst   synchronous active-high reset                             |
// |            bus   line_drive_ctrl_if.slave (en, sensors, servo_l, servo_r,  |
// |                  state_o, lost)                                            |
// | Options  : LINE_DRIVE_RAMP_EN - when defined, servo outputs slew toward    |
// |            their target by at most RAMP_STEP per cycle.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module line_drive_ctrl #(
    parameter int N_SENS    = 4,
    parameter int SPD_W     = 8,
    parameter int SPD_L_FWD = 155,
    parameter int SPD_R_FWD = 137,
    parameter int TURN_CYC  = 500,
    parameter int LOST_CYC  = 1000,
    parameter int CNT_W     = 21,
    parameter int RAMP_STEP = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    line_drive_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN_L = 3'd1,
        TURN_R = 3'd2,
        SEARCH = 3'd3,
        STOP   = 3'd7
    } state_t;

    // Last counter value before the state is left; exits happen here so the
    // counter never needs to reach TURN_CYC / LOST_CYC and cannot wrap.
    localparam logic [CNT_W-1:0] c_TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] c_LOST_LAST = CNT_W'(LOST_CYC - 1);
    localparam logic [SPD_W-1:0] c_SPD_L     = SPD_W'(SPD_L_FWD);
    localparam logic [SPD_W-1:0] c_SPD_R     = SPD_W'(SPD_R_FWD);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_last_left;
    logic               w_last_left_nxt;
    logic               r_lost;
    logic               w_lost_nxt;
    logic               w_force_zero;
    logic [SPD_W-1:0]   r_servo_l;
    logic [SPD_W-1:0]   r_servo_r;
    logic [SPD_W-1:0]   w_tgt_l;
    logic [SPD_W-1:0]   w_tgt_r;
    logic [SPD_W-1:0]   w_servo_l_nxt;
    logic [SPD_W-1:0]   w_servo_r_nxt;
    logic               w_l;
    logic               w_r;

    assign w_l = |bus.sensors[N_SENS-1:N_SENS/2];
    assign w_r = |bus.sensors[N_SENS/2-1:0];

    // Next-state, counter, direction memory and lost flag
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = '0;
        w_last_left_nxt = r_last_left;
        w_lost_nxt      = 1'b0;
        w_force_zero    = 1'b0;

        if (!bus.en) begin
            w_state_nxt  = IDLE;
            w_force_zero = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_l && !w_r) begin
                        w_state_nxt     = TURN_L;
                        w_last_left_nxt = 1'b1;
                    end else if (!w_l && w_r) begin
                        w_state_nxt     = TURN_R;
                        w_last_left_nxt = 1'b0;
                    end else if (!w_l && !w_r) begin
                        w_state_nxt = SEARCH;
                    end
                end
                TURN_L, TURN_R: begin
                    // Sensors are ignored for the full turn duration
                    if (r_cnt == c_TURN_LAST) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                SEARCH: begin
                    // Reacquiring the line beats the timeout on the same cycle
                    if (w_l || w_r) begin
                        w_state_nxt = IDLE;
                    end else if (r_cnt == c_LOST_LAST) begin
                        w_state_nxt = STOP;
                        w_lost_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_l || w_r) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_lost_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_force_zero = 1'b1;
                end
            endcase
        end
    end

    // Servo targets follow the state being entered, so servo outputs change
    // on the same edge as the state register.
    always_comb begin
        w_tgt_l = '0;
        w_tgt_r = '0;
        case (w_state_nxt)
            IDLE: begin
                w_tgt_l = c_SPD_L;
                w_tgt_r = c_SPD_R;
            end
            TURN_L: begin
                w_tgt_r = c_SPD_R;
            end
            TURN_R: begin
                w_tgt_l = c_SPD_L;
            end
            SEARCH: begin
                if (w_last_left_nxt) begin
                    w_tgt_r = c_SPD_R;
                end else begin
                    w_tgt_l = c_SPD_L;
                end
            end
            default: begin
                w_tgt_l = '0;
                w_tgt_r = '0;
            end
        endcase
    end

`ifdef LINE_DRIVE_RAMP_EN
    localparam logic [SPD_W-1:0] c_STEP = SPD_W'(RAMP_STEP);

    // Move toward the target by at most c_STEP, landing exactly on it
    function automatic logic [SPD_W-1:0] f_ramp(
        input logic [SPD_W-1:0] cur,
        input logic [SPD_W-1:0] tgt
    );
        logic [SPD_W-1:0] diff;
        if (tgt > cur) begin
            diff   = tgt - cur;
            f_ramp = (diff > c_STEP) ? cur + c_STEP : tgt;
        end else begin
            diff   = cur - tgt;
            f_ramp = (diff > c_STEP) ? cur - c_STEP : tgt;
        end
    endfunction

    always_comb begin
        w_servo_l_nxt = f_ramp(r_servo_l, w_tgt_l);
        w_servo_r_nxt = f_ramp(r_servo_r, w_tgt_r);
        if (w_force_zero) begin
            w_servo_l_nxt = '0;
            w_servo_r_nxt = '0;
        end
    end
`else
    logic [SPD_W-1:0] w_unused_ramp_step;
    assign w_unused_ramp_step = SPD_W'(RAMP_STEP);

    always_comb begin
        w_servo_l_nxt = w_tgt_l;
        w_servo_r_nxt = w_tgt_r;
        if (w_force_zero) begin
            w_servo_l_nxt = '0;
            w_servo_r_nxt = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last_left <= 1'b0;
            r_lost      <= 1'b0;
            r_servo_l   <= '0;
            r_servo_r   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last_left <= w_last_left_nxt;
            r_lost      <= w_lost_nxt;
            r_servo_l   <= w_servo_l_nxt;
            r_servo_r   <= w_servo_r_nxt;
        end
    end

    assign bus.servo_l = r_servo_l;
    assign bus.servo_r = r_servo_r;
    assign bus.state_o = r_state;
    assign bus.lost    = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_line_drive_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_line_drive_ctrl                                               |
// | Purpose  : Self-checking bench for line_drive_ctrl. A driver issues        |
// |            directed and random stimulus and pushes the reference model's  |
// |            expected outputs into a queue; a monitor pops and compares     |
// |            after every rising edge.                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_line_drive_ctrl;

    localparam int N_SENS    = 4;
    localparam int SPD_W     = 8;
    localparam int SPD_L_FWD = 155;
    localparam int SPD_R_FWD = 137;
    localparam int TURN_CYC  = 500;
    localparam int LOST_CYC  = 1000;
    localparam int RAMP_STEP = 4;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] sl;
        logic [7:0] sr;
        logic       lost;
    } exp_t;

    logic clk;
    logic rst;
    line_drive_ctrl_if #(.N_SENS(N_SENS), .SPD_W(SPD_W)) bus ();

    line_drive_ctrl #(
        .N_SENS(N_SENS), .SPD_W(SPD_W), .SPD_L_FWD(SPD_L_FWD), .SPD_R_FWD(SPD_R_FWD),
        .TURN_CYC(TURN_CYC), .LOST_CYC(LOST_CYC), .CNT_W(21), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 0;

    // Reference model: behaviour expressed as a mode, a "cycles spent" tally
    // and the servo values, advanced once per clock edge.
    int m_mode    = 0;   // 0 idle, 1 turn left, 2 turn right, 3 search, 7 stop
    int m_spent   = 0;
    bit m_left    = 0;
    bit m_lost    = 0;
    int m_sl      = 0;
    int m_sr      = 0;

    function automatic int slew(int cur, int tgt);
`ifdef LINE_DRIVE_RAMP_EN
        if (tgt > cur) return (tgt - cur > RAMP_STEP) ? cur + RAMP_STEP : tgt;
        return (cur - tgt > RAMP_STEP) ? cur - RAMP_STEP : tgt;
`else
        return tgt;
`endif
    endfunction

    task automatic model_step(input bit r, input bit e, input logic [3:0] s);
        bit L;
        bit R;
        int tl;
        int tr;
        L = s[3] | s[2];
        R = s[1] | s[0];
        if (r) begin
            m_mode = 0; m_spent = 0; m_left = 0; m_lost = 0; m_sl = 0; m_sr = 0;
            return;
        end
        if (!e) begin
            m_mode = 0; m_spent = 0; m_lost = 0; m_sl = 0; m_sr = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (L && !R)      begin m_mode = 1; m_left = 1; m_spent = 0; end
                else if (!L && R) begin m_mode = 2; m_left = 0; m_spent = 0; end
                else if (!L && !R) begin m_mode = 3; m_spent = 0; end
            end
            1, 2: begin
                m_spent++;
                if (m_spent == TURN_CYC) m_mode = 0;
            end
            3: begin
                if (L || R) m_mode = 0;
                else begin
                    m_spent++;
                    if (m_spent == LOST_CYC) begin m_mode = 7; m_lost = 1; end
                end
            end
            default: begin
                if (L || R) begin m_mode = 0; m_lost = 0; end
            end
        endcase
        // Search steers like the last turn taken
        tl = SPD_L_FWD; tr = SPD_R_FWD;
        if (m_mode == 1 || (m_mode == 3 && m_left))  tl = 0;
        if (m_mode == 2 || (m_mode == 3 && !m_left)) tr = 0;
        if (m_mode == 7) begin tl = 0; tr = 0; end
        m_sl = slew(m_sl, tl);
        m_sr = slew(m_sr, tr);
    endtask

    task automatic cyc(input bit r, input bit e, input logic [3:0] s);
        exp_t x;
        @(negedge clk);
        rst         = r;
        bus.en      = e;
        bus.sensors = s;
        model_step(r, e, s);
        x.st   = 3'(m_mode);
        x.sl   = 8'(m_sl);
        x.sr   = 8'(m_sr);
        x.lost = m_lost;
        q_exp.push_back(x);
    endtask

    // Monitor: every edge the DUT presents a fresh output set
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                x = q_exp.pop_front();
                n_tests++;
                if (bus.state_o !== x.st || bus.servo_l !== x.sl ||
                    bus.servo_r !== x.sr || bus.lost !== x.lost) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got st=%0d l=%0d r=%0d lost=%0b, expected st=%0d l=%0d r=%0d lost=%0b",
                             $time, bus.state_o, bus.servo_l, bus.servo_r, bus.lost,
                             x.st, x.sl, x.sr, x.lost);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.sensors = '0;
        repeat (2) cyc(1, 1, 4'b0000);

        // Straight ahead from reset
        repeat (45) cyc(0, 1, 4'b1001);

        // Left turn lasting exactly TURN_CYC, then back to IDLE
        cyc(0, 1, 4'b0100);
        repeat (TURN_CYC + 5) cyc(0, 1, 4'b1111);

        // Right turn, search, timeout to STOP, then recovery
        cyc(0, 1, 4'b0001);
        while (m_mode != 3) cyc(0, 1, 4'b0000);
        repeat (LOST_CYC + 3) cyc(0, 1, 4'b0000);
        repeat (3) cyc(0, 1, 4'b0001);

        // Sensor arrives on the timeout cycle: search exits to IDLE
        cyc(0, 1, 4'b0001);
        while (m_mode != 3) cyc(0, 1, 4'b0000);
        repeat (LOST_CYC - 1) cyc(0, 1, 4'b0000);
        cyc(0, 1, 4'b0010);
        repeat (3) cyc(0, 1, 4'b1111);

        // en dropped mid left turn
        cyc(0, 1, 4'b1000);
        repeat (200) cyc(0, 1, 4'b1111);
        cyc(0, 0, 4'b1111);
        repeat (3) cyc(0, 1, 4'b1111);

        // rst mid search, no residual count afterwards
        cyc(0, 1, 4'b0000);
        repeat (300) cyc(0, 1, 4'b0000);
        cyc(1, 1, 4'b0000);
        repeat (LOST_CYC + 2) cyc(0, 1, 4'b0000);
        cyc(0, 1, 4'b1001);

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            logic [3:0] s;
            bit r;
            bit e;
            s = 4'($urandom);
            if ($urandom_range(0, 9) < 3) s = 4'b0000;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 79) != 0);
            cyc(r, e, s);
        end

        @(negedge clk);
        @(negedge clk);
        if (q_exp.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q_exp.size());
        end
        done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time bound in case stimulus stalls
    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout: simulation did not complete, required completion");
            $fatal(1, "timeout");
        end
    end

endmodule
`default_nettype wire
